// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and hazard_ctrl.
// With HAZARD_PERF_EN defined, the bundle also carries the performance counters.
interface hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_branch_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_en;
    logic        mem_wb_bubble;
    logic [1:0]  state;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_count;
    logic [31:0] perf_mem_wait_cycles;
`endif

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_req, mem_ready,
        output pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en,
               mem_wb_bubble, state
`ifdef HAZARD_PERF_EN
        , output perf_stall_cycles, perf_flush_count, perf_mem_wait_cycles
`endif
    );

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_req, mem_ready,
        input  pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en,
               mem_wb_bubble, state
`ifdef HAZARD_PERF_EN
        , input perf_stall_cycles, perf_flush_count, perf_mem_wait_cycles
`endif
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait > taken branch > load-use.
// Optional HAZARD_PERF_EN adds stall, flush and memory-wait performance counters.
module hazard_ctrl #(
    parameter int unsigned LOAD_USE_STALLS = 1,
    parameter int unsigned CNT_W           = 3
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'(LOAD_USE_STALLS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(1);

    state_e           state_q, state_d, ctx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu, mw, lu_bubble, br_flush, mw_freeze;

    assign lu = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                ((hz.id_uses_rs1 && (hz.ex_rd == hz.id_rs1)) ||
                 (hz.id_uses_rs2 && (hz.ex_rd == hz.id_rs2)));
    assign mw = hz.mem_req && !hz.mem_ready;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        hz.pc_en         = 1'b1;
        hz.if_id_en      = 1'b1;
        hz.if_id_flush   = 1'b0;
        hz.id_ex_flush   = 1'b0;
        hz.ex_mem_en     = 1'b1;
        hz.mem_wb_bubble = 1'b0;
        lu_bubble        = 1'b0;
        br_flush         = 1'b0;
        mw_freeze        = 1'b0;

        // Leaving MEM_WAIT resumes whichever context the saved counter implies.
        ctx = state_q;
        if (state_q == MEM_WAIT) begin
            ctx = (cnt_q != '0) ? STALL : RUN;
        end

        if (reset) begin
            hz.pc_en         = 1'b0;
            hz.if_id_en      = 1'b0;
            hz.if_id_flush   = 1'b1;
            hz.id_ex_flush   = 1'b1;
            hz.ex_mem_en     = 1'b0;
            hz.mem_wb_bubble = 1'b1;
            state_d          = RUN;
            cnt_d            = '0;
        end else if (mw) begin
            hz.pc_en         = 1'b0;
            hz.if_id_en      = 1'b0;
            hz.ex_mem_en     = 1'b0;
            hz.mem_wb_bubble = 1'b1;
            mw_freeze        = 1'b1;
            state_d          = MEM_WAIT;
        end else begin
            case (ctx)
                STALL: begin
                    // EX holds a bubble, so branch and load-use inputs are meaningless here.
                    hz.pc_en       = 1'b0;
                    hz.if_id_en    = 1'b0;
                    hz.id_ex_flush = 1'b1;
                    lu_bubble      = 1'b1;
                    cnt_d          = cnt_q - CNT_LAST;
                    state_d        = (cnt_q == CNT_LAST) ? RUN : STALL;
                end
                default: begin
                    state_d = RUN;
                    if (hz.ex_branch_taken) begin
                        hz.if_id_flush = 1'b1;
                        hz.id_ex_flush = 1'b1;
                        br_flush       = 1'b1;
                    end else if (lu) begin
                        hz.pc_en       = 1'b0;
                        hz.if_id_en    = 1'b0;
                        hz.id_ex_flush = 1'b1;
                        lu_bubble      = 1'b1;
                        if (LOAD_USE_STALLS > 1) begin
                            state_d = STALL;
                            cnt_d   = STALL_INIT;
                        end
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    assign hz.state = state_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q, perf_mw_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_mw_q    <= '0;
        end else begin
            perf_stall_q <= perf_stall_q + 32'(lu_bubble);
            perf_flush_q <= perf_flush_q + 32'(br_flush);
            perf_mw_q    <= perf_mw_q + 32'(mw_freeze);
        end
    end

    assign hz.perf_stall_cycles    = perf_stall_q;
    assign hz.perf_flush_count     = perf_flush_q;
    assign hz.perf_mem_wait_cycles = perf_mw_q;
`endif
endmodule
